// File: rtl/pll_reset_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Optional lock-loss filter: PLL_RST_SEQ_LOCK_FILTER_EN.
package pll_reset_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int CNT_W_DEFAULT = 8;

    // Timer only ever needs to reach (largest cycle count - 1).
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_sync_2ff.sv
// Two-flop synchronizer, asynchronous active-high reset to 0.
module pll_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Lock-qualified reset sequencer on the free-running reference clock.
// Define PLL_RST_SEQ_LOCK_FILTER_EN to debounce lock loss in RUN.
module pll_reset_sequencer
    import pll_reset_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 10,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int CNT_W               = CNT_W_DEFAULT,
    parameter int GLITCH_CYCLES       = 4
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             sw_reset_req,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] timeout_count,
    output logic [CNT_W-1:0] relock_count
);

    localparam int TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);

    localparam logic [TW-1:0] RST_LAST     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);

    seq_state_t    st;
    seq_state_t    nxt;
    logic [TW-1:0] timer;
    logic          locked_s;
    logic          lock_loss;
    logic          tmo_inc;
    logic          rel_inc;

    pll_sync_2ff u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

`ifdef PLL_RST_SEQ_LOCK_FILTER_EN
    localparam int FW = (GLITCH_CYCLES < 2) ? 1 : $clog2(GLITCH_CYCLES);
    localparam logic [FW-1:0] FLT_LAST = FW'(GLITCH_CYCLES - 1);

    logic [FW-1:0] flt_cnt;

    // Loss is declared on the GLITCH_CYCLES-th consecutive low sample.
    assign lock_loss = !locked_s && (flt_cnt == FLT_LAST);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            flt_cnt <= '0;
        end else if (st != RUN || locked_s || lock_loss) begin
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end
`else
    assign lock_loss = !locked_s;
`endif

    always_comb begin
        nxt     = st;
        tmo_inc = 1'b0;
        rel_inc = 1'b0;
        if (sw_reset_req) begin
            nxt = PLL_RST;
        end else begin
            case (st)
                PLL_RST: begin
                    if (timer == RST_LAST) nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        nxt = STABLE;
                    end else if (timer == TIMEOUT_LAST) begin
                        nxt     = PLL_RST;
                        tmo_inc = 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        nxt = WAIT_LOCK;
                    end else if (timer == STABLE_LAST) begin
                        nxt = RUN;
                    end
                end
                RUN: begin
                    if (lock_loss) begin
                        nxt     = PLL_RST;
                        rel_inc = 1'b1;
                    end
                end
                default: nxt = PLL_RST;
            endcase
        end
    end

    // Outputs are registered from the next state so they track st exactly.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            st            <= PLL_RST;
            timer         <= '0;
            timeout_count <= '0;
            relock_count  <= '0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
        end else begin
            st      <= nxt;
            pll_rst <= (nxt == PLL_RST);
            sys_rst <= (nxt != RUN);
            ready   <= (nxt == RUN);
            if (nxt != st || sw_reset_req) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (tmo_inc && timeout_count != '1) begin
                timeout_count <= timeout_count + 1'b1;
            end
            if (rel_inc && relock_count != '1) begin
                relock_count <= relock_count + 1'b1;
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer (RST=4, TIMEOUT=32, STABLE=8).
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [1:0] state;
    logic [7:0] timeout_count;
    logic [7:0] relock_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   steps;
        logic locked;
        logic sw;
        int   st;
        logic prst;
        logic srst;
        logic rdy;
        int   tmo;
        int   rel;
    } vec_t;

    vec_t tbl[12];

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .STABLE_CYCLES       (8),
        .CNT_W               (8),
        .GLITCH_CYCLES       (4)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .sw_reset_req  (sw_reset_req),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .state         (state),
        .timeout_count (timeout_count),
        .relock_count  (relock_count)
    );

    always #5 refclk = ~refclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic do_reset(input logic lk);
        rst          = 1'b1;
        pll_locked   = lk;
        sw_reset_req = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int max);
        for (int i = 0; i < max && !ready; i++) step(1);
        check(name, int'(ready), 1);
    endtask

    task automatic drop(input int n);
        pll_locked = 1'b0;
        step(n);
        pll_locked = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 0};
        tbl[1]  = '{3, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 0};
        tbl[2]  = '{1, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[3]  = '{1, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[4]  = '{7, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[5]  = '{1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1, 0, 0};
        tbl[6]  = '{5, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1, 0, 0};
        tbl[7]  = '{1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0, 0, 0};
        tbl[8]  = '{3, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 0};
        tbl[9]  = '{1, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[10] = '{1, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[11] = '{8, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1, 0, 0};

        rst          = 1'b1;
        pll_locked   = 1'b1;
        sw_reset_req = 1'b0;
        #1;
        check("rst_state", int'(state), 0);
        check("rst_pll_rst", int'(pll_rst), 1);
        check("rst_sys_rst", int'(sys_rst), 1);
        check("rst_ready", int'(ready), 0);

        // Start-up with PLL locked, then a software restart from RUN.
        do_reset(1'b1);
        for (int i = 0; i < 12; i++) begin
            pll_locked   = tbl[i].locked;
            sw_reset_req = tbl[i].sw;
            step(tbl[i].steps);
            check($sformatf("vec%0d_state", i), int'(state), tbl[i].st);
            check($sformatf("vec%0d_pll_rst", i), int'(pll_rst), int'(tbl[i].prst));
            check($sformatf("vec%0d_sys_rst", i), int'(sys_rst), int'(tbl[i].srst));
            check($sformatf("vec%0d_ready", i), int'(ready), int'(tbl[i].rdy));
            check($sformatf("vec%0d_tmo", i), int'(timeout_count), tbl[i].tmo);
            check($sformatf("vec%0d_rel", i), int'(relock_count), tbl[i].rel);
        end
        sw_reset_req = 1'b0;

        // One-cycle lock glitch in STABLE at timer 5.
        do_reset(1'b1);
        step(10);
        check("stb_pre", int'(state), 2);
        drop(1);
        step(1);
        check("stb_e12", int'(state), 2);
        step(1);
        check("stb_e13_wait", int'(state), 1);
        check("stb_e13_sys", int'(sys_rst), 1);
        step(1);
        check("stb_e14", int'(state), 2);
        step(7);
        check("stb_no_early", int'(ready), 0);
        step(1);
        check("stb_run", int'(state), 3);
        check("stb_ready", int'(ready), 1);

        // Lock drop while in RUN.
`ifndef PLL_RST_SEQ_LOCK_FILTER_EN
        drop(1);
        step(1);
        check("run_e2", int'(state), 3);
        step(1);
        check("run_loss_state", int'(state), 0);
        check("run_loss_sys", int'(sys_rst), 1);
        check("run_loss_pll", int'(pll_rst), 1);
        check("run_loss_rel", int'(relock_count), 1);
`else
        drop(1);
        step(10);
        check("flt_glitch_state", int'(state), 3);
        check("flt_glitch_rel", int'(relock_count), 0);
        drop(4);
        step(1);
        check("flt_e5", int'(state), 3);
        step(1);
        check("flt_loss_state", int'(state), 0);
        check("flt_loss_pll", int'(pll_rst), 1);
        check("flt_loss_rel", int'(relock_count), 1);
`endif
        wait_ready("relock1_ready", 60);

        // Two more losses, then asynchronous reset mid-RUN.
        for (int k = 0; k < 2; k++) begin
            drop(4);
            wait_ready($sformatf("relock%0d_ready", k + 2), 60);
        end
        check("rel3", int'(relock_count), 3);
        step(2);
        #2;
        rst = 1'b1;
        #1;
        check("async_state", int'(state), 0);
        check("async_pll", int'(pll_rst), 1);
        check("async_sys", int'(sys_rst), 1);
        check("async_ready", int'(ready), 0);
        check("async_rel", int'(relock_count), 0);
        check("async_tmo", int'(timeout_count), 0);
        step(1);
        rst = 1'b0;
        step(12);
        check("reseq_e12", int'(state), 2);
        step(1);
        check("reseq_e13", int'(ready), 1);

        // Lock arriving on the timeout cycle wins.
        do_reset(1'b0);
        step(33);
        pll_locked = 1'b1;
        step(3);
        check("tie_state", int'(state), 2);
        check("tie_tmo", int'(timeout_count), 0);

        // Lock arriving one cycle too late: timeout taken.
        do_reset(1'b0);
        step(34);
        pll_locked = 1'b1;
        step(2);
        check("late_state", int'(state), 0);
        check("late_tmo", int'(timeout_count), 1);

        // Repeated timeouts with no lock, through saturation.
        do_reset(1'b0);
        step(3);
        check("to_pll_e3", int'(pll_rst), 1);
        step(1);
        check("to_pll_e4", int'(pll_rst), 0);
        step(31);
        check("to_e35", int'(state), 1);
        step(1);
        check("to_e36_state", int'(state), 0);
        check("to_e36_pll", int'(pll_rst), 1);
        check("to_e36_tmo", int'(timeout_count), 1);
        for (int k = 2; k <= 300; k++) begin
            step(36);
            check($sformatf("to%0d_state", k), int'(state), 0);
            check($sformatf("to%0d_tmo", k), int'(timeout_count), (k > 255) ? 255 : k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
